// File: rtl/mux_arb_pkg.sv
// Shared types and default sizes for the round-robin datapath mux arbiter.
package mux_arb_pkg;

  localparam int unsigned ARB_NUM_CH     = 8;
  localparam int unsigned ARB_DATA_WIDTH = 32;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first request at or after pointer+1,
// wrapping explicitly from NUM_CH-1 back to 0.
module rr_pick import mux_arb_pkg::*; #(
  parameter  int unsigned NUM_CH = ARB_NUM_CH,
  localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [SEL_W-1:0]  pointer_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [SEL_W-1:0]  idx_o,
  output logic              any_o
);

  int unsigned      cand;
  logic [SEL_W-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Pointer itself is checked last, so the previous winner has lowest priority.
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = 32'(pointer_i) + i;
      if (cand >= NUM_CH) begin
        cand = cand - NUM_CH;
      end
      cand_idx = SEL_W'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        idx_o           = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer steering one of NUM_CH channel words to a valid/ready output.
// Optional MUX_ARB_PRIO_EN adds prio_i: high-priority requests arbitrate first, same pointer.
module mux_rr_arbiter import mux_arb_pkg::*; #(
  parameter  int unsigned DATA_WIDTH = ARB_DATA_WIDTH,
  parameter  int unsigned NUM_CH     = ARB_NUM_CH,
  localparam int unsigned SEL_W      = $clog2(NUM_CH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH-1:0]            req_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
`ifdef MUX_ARB_PRIO_EN
  input  logic [NUM_CH-1:0]            prio_i,
`endif
  output logic [NUM_CH-1:0]            ack_o,
  output logic [NUM_CH-1:0]            grant_o,
  output logic [SEL_W-1:0]             sel_o,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         busy_o
);

  arb_state_e          state_q;
  logic [NUM_CH-1:0]   grant_q;
  logic [SEL_W-1:0]    sel_q;
  logic [SEL_W-1:0]    ptr_q;

  logic [NUM_CH-1:0]   pick_req;
  logic [NUM_CH-1:0]   pick_gnt;
  logic [SEL_W-1:0]    pick_idx;
  logic                pick_any;
  logic                busy;
  logic                sel_req;
  logic                valid;
  logic                accept;
  logic [DATA_WIDTH-1:0] word;

`ifdef MUX_ARB_PRIO_EN
  assign pick_req = (|(req_i & prio_i)) ? (req_i & prio_i) : req_i;
`else
  assign pick_req = req_i;
`endif

  rr_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .req_i     (pick_req),
    .pointer_i (ptr_q),
    .gnt_o     (pick_gnt),
    .idx_o     (pick_idx),
    .any_o     (pick_any)
  );

  // grant_q is the one-hot of sel_q while granted, zero otherwise.
  assign busy    = (state_q == ARB_GRANT);
  assign sel_req = |(req_i & grant_q);
  assign valid   = busy && sel_req && !rst_i;
  assign accept  = valid && out_ready_i;

  always_comb begin
    word = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (grant_q[k]) begin
        word = data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= SEL_W'(NUM_CH - 1);
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_gnt;
            sel_q   <= pick_idx;
            state_q <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (accept) begin
            ptr_q   <= sel_q;
            grant_q <= '0;
            state_q <= ARB_IDLE;
          end else if (!sel_req) begin
            // Abandoned by the requester: drop the grant, keep the pointer.
            grant_q <= '0;
            state_q <= ARB_IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign ack_o       = accept ? grant_q : '0;
  assign grant_o     = grant_q;
  assign sel_o       = sel_q;
  assign out_data_o  = word;
  assign out_valid_o = valid;
  assign busy_o      = busy;

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the 8-channel, 32-bit datapath mux.
- Up to NUM_CH requesters each present a data word with a valid/request. The block grants one requester at a time and steers its word to a single output with a valid/ready handshake.
- Returns a one-cycle acknowledge to the winner and exports the registered channel selector for downstream muxes and debug.
- Sits between the producer channels and the shared output consumer.

Parameters:
- DATA_WIDTH, 32, width of each channel word and of the output word.
- NUM_CH, 8, number of requesters; legal range 2..8.
- SEL_W, $clog2(NUM_CH), selector width; derived, never overridden.

Ports:
- clk_i  input  1  single clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  NUM_CH  per-channel request/valid; must be held until the matching ack_o.
- data_i  input  NUM_CH*DATA_WIDTH  packed channel words; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- ack_o  output  NUM_CH  one-hot, one-cycle pulse when the granted word is accepted.
- grant_o  output  NUM_CH  one-hot registered grant; 0 when idle.
- sel_o  output  SEL_W  registered index of the granted channel.
- out_data_o  output  DATA_WIDTH  word of the granted channel.
- out_valid_o  output  1  out_data_o is valid.
- out_ready_i  input  1  consumer accepts the word when out_valid_o && out_ready_i.
- busy_o  output  1  high in the GRANT state.

Behaviour:
- Reset values: grant_o=0, sel_o=0, out_valid_o=0, ack_o=0, busy_o=0, out_data_o=0. The round-robin pointer resets to NUM_CH-1, so channel 0 has the highest priority first.
- rst_i takes effect at the next clock edge even mid-transfer. An in-flight grant is dropped with no ack.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If req_i != 0, pick the first set request searching upward from pointer+1, wrapping modulo NUM_CH.
  - Register grant_o/sel_o and go to GRANT.
  - If req_i == 0, stay in IDLE.
- GRANT:
  - out_valid_o=1 and out_data_o = data_i[sel_o] (combinational from the registered sel_o, so it tracks data_i live).
  - busy_o=1.
- Accept, i.e. out_valid_o && out_ready_i in GRANT:
  - ack_o[sel_o]=1 in that same cycle (combinational).
  - pointer <= sel_o, grant_o <= 0, go to IDLE.
- Latency: request to out_valid_o is 1 cycle. Every accept is followed by one IDLE cycle, so maximum throughput is 1 word per 2 cycles.
- Abandon: if req_i[sel_o] drops in GRANT without an accept:
  - out_valid_o drops in that same cycle (gated by req_i[sel_o]).
  - Next state is IDLE; pointer is unchanged; no ack.
- Requests arriving or dropping on other channels during GRANT have no effect until the next IDLE cycle.
- Fairness: with all channels requesting continuously, grants follow 0,1,...,NUM_CH-1,0,... A channel waits at most NUM_CH-1 grants.
- Channel indices ≥ NUM_CH are never selected. Pointer wrap from NUM_CH-1 to 0 is explicit, not implied by SEL_W overflow.

Optional Feature:
- Macro MUX_ARB_PRIO_EN.
- Defined: adds input prio_i [NUM_CH].
  - In IDLE, if (req_i & prio_i) != 0, arbitrate round-robin only among those high-priority requests, using the same pointer.
  - Otherwise arbitrate among all requests.
- Undefined: prio_i does not exist and plain round-robin applies.

Decomposition:
- Package mux_arb_pkg:
  - state enum arb_state_e {ARB_IDLE, ARB_GRANT}.
  - Default constants ARB_NUM_CH=8 and ARB_DATA_WIDTH=32.
- Sub-module rr_pick: purely combinational rotating-priority picker.
  - Inputs: req [NUM_CH], pointer [SEL_W].
  - Outputs: one-hot gnt, index idx, any.
  - Top instantiates it once; with MUX_ARB_PRIO_EN, the top muxes its req input between req_i&prio_i and req_i.

Test Plan:
- Reset: hold rst_i 2 cycles with req_i=8'hFF → all outputs 0. First grant after release is channel 0, with sel_o=0 one cycle later.
- Round-robin: req_i=8'hFF held, data_i[k]=32'hA0+k, out_ready_i=1 → accepted words A0,A1,...,A7,A0 at one per 2 cycles, with ack_o pulses 01,02,...,80,01.
- Backpressure: grant channel 3 with out_ready_i=0 for 5 cycles → out_valid_o=1, sel_o=3, no ack, and out_data_o follows data_i[3] changes. Raise out_ready_i → ack_o=8'h08 that cycle.
- Wrap/sparse: req_i=8'h81 with pointer at 7 → grant 0, then 7, then 0.
- Abandon: grant channel 2, then drop req_i[2] → out_valid_o falls that cycle, no ack. With req_i=8'h24 next grant is 2 again (pointer unchanged), otherwise the next requester above 2.
- Reset mid-grant: assert rst_i while in GRANT with out_ready_i=1 → no ack_o at the reset edge. Outputs read 0 the following cycle; the first grant after release is channel 0.
